// File: rtl/h264dc_invtransform.sv
// rtl/h264dc_invtransform.sv - inverse 2x2 chroma DC Hadamard, serial in/out, single-block buffer
module h264dc_invtransform #(
  parameter int IN_W        = 16,
  parameter int OUT_W       = 16,
  parameter int ROUND_SHIFT = 0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  output logic             READYI,
  input  logic             ENABLE,
  input  logic [IN_W-1:0]  XXIN,
  output logic             VALID,
  output logic [OUT_W-1:0] YYOUT,
  input  logic             READYO
);

  // Wide enough for the 4-term sum, the rounding offset and a clamp compare against OUT_W bounds.
  localparam int SW  = (IN_W + 3 > OUT_W + 1) ? IN_W + 3 : OUT_W + 1;
  localparam int RS1 = (ROUND_SHIFT > 0) ? ROUND_SHIFT - 1 : 0;
  localparam logic signed [SW-1:0] RND  = SW'(ROUND_SHIFT > 0) << RS1;
  localparam logic signed [SW-1:0] MAXV = (SW'(1) << (OUT_W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);

  typedef enum logic [1:0] {LOAD, CALC, EMIT} state_t;

  state_t                 state;
  logic [1:0]             cnt;
  logic [1:0]             idx;
  logic signed [IN_W-1:0] coef [4];
  logic [OUT_W-1:0]       res  [4];

  logic signed [SW-1:0] e0, e1, e2, e3;
  logic signed [SW-1:0] s01, d01, s23, d23;
  logic signed [SW-1:0] f    [4];
  logic [OUT_W-1:0]     q    [4];

  function automatic logic [OUT_W-1:0] finish(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] r;
    r = (v + RND) >>> ROUND_SHIFT;
    if (r > MAXV)      finish = MAXV[OUT_W-1:0];
    else if (r < MINV) finish = MINV[OUT_W-1:0];
    else               finish = r[OUT_W-1:0];
  endfunction

  // Butterfly form of the 2x2 Hadamard: row pairs first, then combine.
  always_comb begin
    e0  = SW'(coef[0]);
    e1  = SW'(coef[1]);
    e2  = SW'(coef[2]);
    e3  = SW'(coef[3]);
    s01 = e0 + e1;
    d01 = e0 - e1;
    s23 = e2 + e3;
    d23 = e2 - e3;
    f[0] = s01 + s23;
    f[1] = d01 + d23;
    f[2] = s01 - s23;
    f[3] = d01 - d23;
    for (int k = 0; k < 4; k++) q[k] = finish(f[k]);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= LOAD;
      cnt    <= 2'd0;
      idx    <= 2'd0;
      READYI <= 1'b1;
      VALID  <= 1'b0;
      YYOUT  <= '0;
      for (int k = 0; k < 4; k++) begin
        coef[k] <= '0;
        res[k]  <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (ENABLE) begin
            coef[cnt] <= XXIN;
            cnt       <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state  <= CALC;
              READYI <= 1'b0;
            end
          end
        end
        CALC: begin
          for (int k = 0; k < 4; k++) res[k] <= q[k];
          YYOUT <= q[0];
          VALID <= 1'b1;
          idx   <= 2'd0;
          state <= EMIT;
        end
        EMIT: begin
          if (READYO) begin
            if (idx == 2'd3) begin
              state  <= LOAD;
              VALID  <= 1'b0;
              READYI <= 1'b1;
            end else begin
              idx   <= idx + 2'd1;
              YYOUT <= res[idx + 2'd1];
            end
          end
        end
        default: begin
          state  <= LOAD;
          cnt    <= 2'd0;
          READYI <= 1'b1;
          VALID  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_h264dc_invtransform.sv
// tb/tb_h264dc_invtransform.sv - self-checking bench for h264dc_invtransform
module tb_h264dc_invtransform;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic [15:0] XXIN = '0;
  logic        READYO = 1'b1;
  logic        READYI0, VALID0, READYI2, VALID2;
  logic [15:0] YYOUT0, YYOUT2;

  always #5 CLK = ~CLK;

  h264dc_invtransform #(.IN_W(16), .OUT_W(16), .ROUND_SHIFT(0)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .READYI(READYI0), .ENABLE(ENABLE), .XXIN(XXIN),
    .VALID(VALID0), .YYOUT(YYOUT0), .READYO(READYO));

  h264dc_invtransform #(.IN_W(16), .OUT_W(16), .ROUND_SHIFT(2)) dut2 (
    .CLK(CLK), .RESET_N(RESET_N), .READYI(READYI2), .ENABLE(ENABLE), .XXIN(XXIN),
    .VALID(VALID2), .YYOUT(YYOUT2), .READYO(READYO));

  typedef struct {
    logic [3:0][15:0] x;
    logic [3:0][15:0] y;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [15:0] got0 [4];
  logic [15:0] got2 [4];
  int vcyc, rlow;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0][15:0] mk(input logic [15:0] a, b, c, d);
    logic [3:0][15:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // Reference: direct Hadamard sums on integers, then round and clamp.
  function automatic logic [15:0] model(input logic [3:0][15:0] x, input int s, input int k);
    int c0, c1, c2, c3, v;
    c0 = $signed(x[0]); c1 = $signed(x[1]); c2 = $signed(x[2]); c3 = $signed(x[3]);
    case (k)
      0: v = c0 + c1 + c2 + c3;
      1: v = c0 - c1 + c2 - c3;
      2: v = c0 + c1 - c2 - c3;
      default: v = c0 - c1 - c2 + c3;
    endcase
    if (s > 0) v = (v + (1 << (s - 1))) >>> s;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic send(input logic [3:0][15:0] x, input int gap);
    int b;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        for (int g = 0; g < gap; g++) begin
          ENABLE = 1'b0;
          XXIN = 16'($urandom);
          @(posedge CLK); #1;
        end
      end
      b = 0;
      while (!READYI0 && b < 50) begin
        @(posedge CLK); #1; b++;
      end
      check("send_ready_timeout", 32'(b < 50), 32'd1);
      ENABLE = 1'b1;
      XXIN = x[i];
      @(posedge CLK); #1;
    end
    ENABLE = 1'b0;
  endtask

  task automatic collect(input int sa, input int sl);
    int n, st, budget;
    logic [15:0] held;
    n = 0; st = 0; budget = 0; vcyc = 0; rlow = 0; held = '0;
    while (n < 4 && budget < 100) begin
      if (!READYI0) rlow++;
      if (VALID0) vcyc++;
      if (VALID0 && n == sa && st < sl) begin
        if (st == 0) held = YYOUT0;
        else check("stall_hold", 32'(YYOUT0), 32'(held));
        READYO = 1'b0;
        st++;
      end else begin
        READYO = 1'b1;
      end
      if (VALID0 && READYO) begin
        got0[n] = YYOUT0;
        got2[n] = YYOUT2;
        n++;
      end
      @(posedge CLK); #1;
      budget++;
    end
    check("collect_timeout", 32'(budget < 100), 32'd1);
    check("post_readyi", 32'(READYI0), 32'd1);
    check("post_valid", 32'(VALID0), 32'd0);
  endtask

  task automatic run_block(input logic [3:0][15:0] x, input int gap, input int sa, input int sl);
    send(x, gap);
    collect(sa, sl);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("model_s0_f%0d", k), 32'(got0[k]), 32'(model(x, 0, k)));
      check($sformatf("model_s2_f%0d", k), 32'(got2[k]), 32'(model(x, 2, k)));
    end
    check("valid_cycles", 32'(vcyc), 32'(4 + sl));
    check("readyi_low_cycles", 32'(rlow), 32'(5 + sl));
  endtask

  vec_t tbl [4];

  initial begin
    logic [3:0][15:0] x;
    tbl[0].x = mk(16'd1, 16'd2, 16'd3, 16'd4);
    tbl[0].y = mk(16'h000A, 16'hFFFE, 16'hFFFC, 16'h0000);
    tbl[1].x = mk(16'd10, 16'hFFFE, 16'hFFFC, 16'd0);
    tbl[1].y = mk(16'h0004, 16'h0008, 16'h000C, 16'h0010);
    tbl[2].x = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    tbl[2].y = mk(16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
    tbl[3].x = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    tbl[3].y = mk(16'h8000, 16'h0000, 16'h0000, 16'h0000);

    #12;
    check("rst_readyi", 32'(READYI0), 32'd1);
    check("rst_valid", 32'(VALID0), 32'd0);
    check("rst_yyout", 32'(YYOUT0), 32'd0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    for (int t = 0; t < 4; t++) begin
      run_block(tbl[t].x, 0, 0, 0);
      for (int k = 0; k < 4; k++)
        check($sformatf("tbl%0d_f%0d", t, k), 32'(got0[k]), 32'(tbl[t].y[k]));
      if (t == 1)
        for (int k = 0; k < 4; k++)
          check($sformatf("t2_shift2_f%0d", k), 32'(got2[k]), 32'(k + 1));
    end

    // Input gap of 3 cycles and a 5-cycle stall on f1.
    run_block(tbl[0].x, 3, 1, 5);
    for (int k = 0; k < 4; k++)
      check($sformatf("t4_f%0d", k), 32'(got0[k]), 32'(tbl[0].y[k]));

    // Back-to-back with ENABLE held high and junk offered while READYI is low.
    send(tbl[0].x, 0);
    ENABLE = 1'b1;
    XXIN = 16'h0063;
    collect(0, 0);
    check("t5a_f0", 32'(got0[0]), 32'h000A);
    send(mk(16'd5, 16'd6, 16'd7, 16'd8), 0);
    collect(0, 0);
    check("t5b_f0", 32'(got0[0]), 32'h001A);
    check("t5b_f1", 32'(got0[1]), 32'hFFFE);
    check("t5b_f2", 32'(got0[2]), 32'hFFFC);
    check("t5b_f3", 32'(got0[3]), 32'h0000);

    // Asynchronous reset in the middle of EMIT.
    send(tbl[0].x, 0);
    READYO = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("t6_in_emit", 32'(VALID0), 32'd1);
    #3 RESET_N = 1'b0;
    #1;
    check("t6_valid", 32'(VALID0), 32'd0);
    check("t6_readyi", 32'(READYI0), 32'd1);
    check("t6_yyout", 32'(YYOUT0), 32'd0);
    check("t6_yyout2", 32'(YYOUT2), 32'd0);
    #2 RESET_N = 1'b1;
    @(posedge CLK); #1;
    run_block(tbl[0].x, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      check($sformatf("t6_after_f%0d", k), 32'(got0[k]), 32'(tbl[0].y[k]));

    // Randomised blocks with occasional extremes, gaps and stalls.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 5))
          0: x[i] = 16'h7FFF;
          1: x[i] = 16'h8000;
          default: x[i] = 16'($urandom);
        endcase
      end
      run_block(x, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
